uart_rx_frame: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver used by the UART/ALU top.
- Configurable data width, oversampling ratio, parity mode and stop-bit count.
- Majority-vote mid-bit sampling and false-start rejection.
- Per-frame parity, framing and break status.
- valid/ready output handshake with overrun reporting.
- Fed by the existing baudrate_generator tick. Drives the command/operand interface logic in place of the old receiver.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 81 ++++++++
 rtl/uart_rx_frame.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver state encoding and small helper functions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_e;

    // Tick index of the centre sample inside one bit period.
    function automatic int mid_of(input int oversample);
        return oversample / 2 - 1;
    endfunction

    // Two-out-of-three majority.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: two-flop synchroniser, falling-edge
// detector, oversampling tick counter and three-sample majority vote.
// bit_strobe pulses for one clk right after the MID+1 tick with the voted
// value on bit_val.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic rx,
    input  logic restart,
    output logic rx_line,
    output logic fall_edge,
    output logic bit_val,
    output logic bit_strobe
);

    localparam int MID = mid_of(OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_LO   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(MID);
    localparam logic [CW-1:0] CNT_HI   = CW'(MID + 1);

    logic          rx_p0, rx_p1, rx_p2;
    logic [CW-1:0] cnt;
    logic          samp_lo, samp_mid;
    logic          vote_hit;

    assign rx_line   = rx_p1;
    assign fall_edge = rx_p2 & ~rx_p1;
    assign vote_hit  = tick && !restart && (cnt == CNT_HI);

    // Synchroniser (p0, p1) plus one history flop (p2) for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    // Tick counter 0..OVERSAMPLE-1, realigned to a detected start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Strobe marks a fresh vote; it is control and is cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_strobe <= 1'b0;
        end else begin
            bit_strobe <= vote_hit;
        end
    end

    // Capture the three mid-bit samples and resolve the majority.
    always_ff @(posedge clk) begin
        if (tick && !restart) begin
            if (cnt == CNT_LO)  samp_lo  <= rx_p1;
            if (cnt == CNT_MID) samp_mid <= rx_p1;
        end
        if (vote_hit) begin
            bit_val <= maj3(samp_lo, samp_mid, rx_p1);
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with parity/framing/break status and a
// valid/ready output register that reports dropped frames via overrun.
// The frame state advances on each vote rather than at the bit-period
// wrap: the next vote cannot arrive before the next bit centre anyway, so
// the observable behaviour is the same and the commit lands one clk after
// the final stop vote.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 overrun
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_e state, state_nxt;

    logic                 rx_line, fall_edge, bit_val, bit_strobe;
    logic                 restart, commit;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 last_data, last_stop;

    logic [DATA_BITS-1:0] data_sh;
    logic                 par_acc, par_err_q;
    logic                 zero_acc, stop_err_q, stop0_zero_q;
    logic                 stop0_zero_now, frame_brk, frame_ferr;

    function automatic logic parity_fail(input logic acc, input logic pbit);
        case (PARITY_MODE)
            PAR_EVEN: return acc ^ pbit;
            PAR_ODD:  return ~(acc ^ pbit);
            default:  return 1'b0;
        endcase
    endfunction

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .rx        (rx),
        .restart   (restart),
        .rx_line   (rx_line),
        .fall_edge (fall_edge),
        .bit_val   (bit_val),
        .bit_strobe(bit_strobe)
    );

    assign last_data      = (bit_idx == LAST_BIT);
    assign last_stop      = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign stop0_zero_now = (stop_idx == 1'b0) ? ~bit_val : stop0_zero_q;
    assign frame_brk      = zero_acc & stop0_zero_now;
    assign frame_ferr     = stop_err_q | ~bit_val;

    // Next-state decode; restart realigns the sampler, commit loads the output.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    restart   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_strobe) state_nxt = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (bit_strobe && last_data)
                    state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_strobe) state_nxt = STOP;
            end
            STOP: begin
                if (bit_strobe && last_stop) begin
                    commit    = 1'b1;
                    state_nxt = frame_brk ? BRK_WAIT : IDLE;
                end
            end
            BRK_WAIT: begin
                if (rx_line) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and per-frame bit/stop counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else if (bit_strobe) begin
                if (state == DATA) bit_idx  <= bit_idx + 1'b1;
                if (state == STOP) stop_idx <= 1'b1;
            end
        end
    end

    // Frame accumulators: payload shift, parity fold, break and stop tracking.
    always_ff @(posedge clk) begin
        if (restart) begin
            par_acc      <= 1'b0;
            par_err_q    <= 1'b0;
            zero_acc     <= 1'b1;
            stop_err_q   <= 1'b0;
            stop0_zero_q <= 1'b0;
        end else if (bit_strobe) begin
            case (state)
                DATA: begin
                    data_sh <= {bit_val, data_sh[DATA_BITS-1:1]};
                    par_acc <= par_acc ^ bit_val;
                    if (bit_val) zero_acc <= 1'b0;
                end
                PARITY: begin
                    par_err_q <= parity_fail(par_acc, bit_val);
                    if (bit_val) zero_acc <= 1'b0;
                end
                STOP: begin
                    if (!bit_val) stop_err_q <= 1'b1;
                    if (stop_idx == 1'b0) stop0_zero_q <= ~bit_val;
                end
                default: ;
            endcase
        end
    end

    // Output register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            brk        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= data_sh;
                    parity_err <= par_err_q;
                    frame_err  <= frame_ferr;
                    brk        <= frame_brk;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
